// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer: FSM state encoding and widths.
package regfile_write_buffer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WCOUNT_MAX = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/regfile_write_buffer_wb_fifo.sv
// Small power-of-two FIFO holding {regnum, data} entries for the write buffer.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Buffers the register-sequence writer's (regnum, data) stream and drains it onto the shared
// register-file write port. Optional macro REGFILE_ZERO_FILTER_EN drops register-0 writes.
module regfile_write_buffer
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_regnum,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              seq_done,
    input  logic              port_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [7:0]        write_count,
    output logic              batch_done,
    output logic [1:0]        dbg_state
);

    localparam int EW = ADDR_W + DATA_W;

    // Handshake: an entry transfers at a rising edge where in_valid and in_ready are both high;
    // upstream holds in_regnum/in_data stable while in_valid is high and in_ready is low.
    logic          fifo_full, fifo_empty;
    logic          push_acc, store, pop;
    logic [EW-1:0] head;

    wb_state_e         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [7:0]        write_count_q, write_count_d;
    logic              batch_done_q, batch_done_d;

    assign in_ready = ~fifo_full;
    assign push_acc = in_valid & ~fifo_full;
`ifdef REGFILE_ZERO_FILTER_EN
    assign store = push_acc & (in_regnum != '0);
`else
    assign store = push_acc;
`endif
    assign pop = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) & ~fifo_empty & ~port_busy;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (store),
        .pop   (pop),
        .wdata ({in_regnum, in_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        rf_we_d       = pop;
        rf_addr_d     = rf_addr_q;
        rf_wdata_d    = rf_wdata_q;
        write_count_d = write_count_q;
        if (pop) begin
            {rf_addr_d, rf_wdata_d} = head;
            if (write_count_q != 8'(WCOUNT_MAX)) write_count_d = write_count_q + 8'd1;
        end
        case (state_q)
            ST_IDLE, ST_DONE: if (push_acc) begin
                state_d       = ST_FILL;
                write_count_d = '0;
            end
            ST_FILL:  if (seq_done) state_d = ST_DRAIN;
            // A push landing in an empty FIFO keeps the batch open until it drains.
            ST_DRAIN: if (fifo_empty && !store) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        batch_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rf_we_q       <= 1'b0;
            rf_addr_q     <= '0;
            rf_wdata_q    <= '0;
            write_count_q <= '0;
            batch_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_addr_q     <= rf_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            write_count_q <= write_count_d;
            batch_done_q  <= batch_done_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_addr     = rf_addr_q;
    assign rf_wdata    = rf_wdata_q;
    assign write_count = write_count_q;
    assign batch_done  = batch_done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Testbench for regfile_write_buffer: queue-based reference model, negedge scoreboard, scenario tasks.
module tb_regfile_write_buffer;
    import regfile_write_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int EW    = AW + DW;
`ifdef REGFILE_ZERO_FILTER_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [AW-1:0] in_regnum;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          seq_done;
    logic          port_busy;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [7:0]    write_count;
    logic          batch_done;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: buffered entries, batch phase, commit count, expected write stream.
    wb_state_e     m_state = ST_IDLE;
    logic [EW-1:0] m_fifo[$];
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] obs_q[$];
    int            m_count = 0;
    logic          m_we = 1'b0;
    logic [EW-1:0] sb_e;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    regfile_write_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_regnum   (in_regnum),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .seq_done    (seq_done),
        .port_busy   (port_busy),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .write_count (write_count),
        .batch_done  (batch_done),
        .dbg_state   (dbg_state)
    );

    function automatic void model_reset();
        m_state = ST_IDLE;
        m_fifo.delete();
        exp_q.delete();
        m_count = 0;
        m_we    = 1'b0;
    endfunction

    // Advance one clock; the model applies the buffer rules to the inputs held across the edge.
    task automatic step();
        bit acc, keep, was_empty, popped;
        @(posedge clock);
        if (reset === 1'b0) begin
            model_reset();
        end else begin
            was_empty = (m_fifo.size() == 0);
            acc       = in_valid && (m_fifo.size() < DEPTH);
            keep      = acc && !(ZF && in_regnum == '0);
            popped    = (m_state == ST_FILL || m_state == ST_DRAIN) && !was_empty && !port_busy;
            m_we      = popped;
            if (popped) begin
                exp_q.push_back(m_fifo.pop_front());
                if (m_count < 255) m_count++;
            end
            case (m_state)
                ST_IDLE, ST_DONE: if (acc) begin
                    m_state = ST_FILL;
                    m_count = 0;
                end
                ST_FILL: if (seq_done) m_state = ST_DRAIN;
                default: if (was_empty && !keep) m_state = ST_DONE;
            endcase
            if (keep) m_fifo.push_back({in_regnum, in_data});
        end
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit took = 0;
        in_valid  = 1'b1;
        in_regnum = a;
        in_data   = d;
        for (int i = 0; i < 64 && !took; i++) begin
            took = (in_ready === 1'b1);
            step();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!took) begin
            n_err++;
            $display("FAIL push_accept: got no accept want accept reg=%0d", a);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        n_cmp++;
        if (rf_we !== m_we) begin
            n_err++;
            $display("FAIL sb_rf_we: got %b want %b at %0t", rf_we, m_we, $time);
        end
        if (rf_we === 1'b1) obs_q.push_back(rf_addr);
        if (m_we) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_exp_empty: got empty want entry at %0t", $time);
            end else begin
                sb_e = exp_q.pop_front();
                n_cmp++;
                if ({rf_addr, rf_wdata} !== sb_e) begin
                    n_err++;
                    $display("FAIL sb_entry: got %0h/%0h want %0h/%0h at %0t",
                             rf_addr, rf_wdata, sb_e[EW-1:DW], sb_e[DW-1:0], $time);
                end
            end
        end
        n_cmp++;
        if (in_ready !== (m_fifo.size() < DEPTH)) begin
            n_err++;
            $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, m_fifo.size() < DEPTH, $time);
        end
        n_cmp++;
        if (write_count !== 8'(m_count)) begin
            n_err++;
            $display("FAIL sb_write_count: got %0d want %0d at %0t", write_count, m_count, $time);
        end
        n_cmp++;
        if (batch_done !== (m_state == ST_DONE)) begin
            n_err++;
            $display("FAIL sb_batch_done: got %b want %b at %0t", batch_done, m_state == ST_DONE, $time);
        end
        n_cmp++;
        if (dbg_state !== m_state) begin
            n_err++;
            $display("FAIL sb_state: got %0d want %0d at %0t", dbg_state, m_state, $time);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_cmp++;
        if ({rf_we, rf_addr, rf_wdata, write_count, batch_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%0h/%0h/%0d/%b want all 0",
                     rf_we, rf_addr, rf_wdata, write_count, batch_done);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int exp_regs[5] = '{8, 7, 6, 5, 4};
        obs_q.delete();
        for (int i = 0; i < 5; i++) push(AW'(exp_regs[i]), DW'(32'h100 + exp_regs[i]));
        seq_done = 1'b1;
        for (int i = 0; i < 40 && batch_done !== 1'b1; i++) step();
        n_cmp++;
        if (batch_done !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done: got %b want 1", batch_done);
        end
        n_cmp++;
        if (write_count !== 8'd5) begin
            n_err++;
            $display("FAIL basic_count: got %0d want 5", write_count);
        end
        n_cmp++;
        if (obs_q.size() != 5) begin
            n_err++;
            $display("FAIL basic_writes: got %0d want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (obs_q[i] !== AW'(exp_regs[i])) begin
                    n_err++;
                    $display("FAIL basic_order: got %0d want %0d", obs_q[i], exp_regs[i]);
                end
            end
        end
        seq_done = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        obs_q.delete();
        port_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(AW'(20 + i), $urandom);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
        end
        in_valid  = 1'b1;
        in_regnum = AW'(24);
        in_data   = $urandom;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (obs_q.size() != 0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stall: got %0d writes ready=%b want 0 writes ready=0", obs_q.size(), in_ready);
        end
        port_busy = 1'b0;
        push(AW'(24), in_data);
        push(AW'(25), $urandom);
        seq_done = 1'b1;
        for (int i = 0; i < 40 && batch_done !== 1'b1; i++) step();
        n_cmp++;
        if (batch_done !== 1'b1 || write_count !== 8'd6) begin
            n_err++;
            $display("FAIL bp_done: got done=%b count=%0d want done=1 count=6", batch_done, write_count);
        end
        n_cmp++;
        if (obs_q.size() != 6) begin
            n_err++;
            $display("FAIL bp_writes: got %0d want 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (obs_q[i] !== AW'(20 + i)) begin
                    n_err++;
                    $display("FAIL bp_order: got %0d want %0d", obs_q[i], 20 + i);
                end
            end
        end
        seq_done = 1'b0;
        step();
    endtask

    task automatic test_toggle();
        logic prev_busy;
        obs_q.delete();
        port_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(AW'(9 + i), DW'(32'h900 + i));
        seq_done = 1'b1;
        for (int i = 0; i < 40 && batch_done !== 1'b1; i++) begin
            port_busy = ~port_busy;
            prev_busy = port_busy;
            step();
            n_cmp++;
            if (rf_we === 1'b1 && prev_busy) begin
                n_err++;
                $display("FAIL toggle_busy_write: got rf_we=1 want 0 after busy edge");
            end
        end
        port_busy = 1'b0;
        n_cmp++;
        if (batch_done !== 1'b1 || obs_q.size() != 4) begin
            n_err++;
            $display("FAIL toggle_done: got done=%b writes=%0d want done=1 writes=4", batch_done, obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_q[i] !== AW'(9 + i)) begin
                    n_err++;
                    $display("FAIL toggle_order: got %0d want %0d", obs_q[i], 9 + i);
                end
            end
        end
        seq_done = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        port_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(AW'(1 + i), $urandom);
        obs_q.delete();
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({rf_we, rf_addr, rf_wdata, write_count, batch_done} !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b/%0h/%0h/%0d/%b ready=%b want zeros ready=1",
                     rf_we, rf_addr, rf_wdata, write_count, batch_done, in_ready);
        end
        port_busy = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_no_write: got %0d writes want 0", obs_q.size());
        end
    endtask

    task automatic test_zero();
        int want = ZF ? 1 : 2;
        obs_q.delete();
        push(AW'(0), 32'hdead0000);
        push(AW'(8), 32'h108);
        seq_done = 1'b1;
        for (int i = 0; i < 40 && batch_done !== 1'b1; i++) step();
        n_cmp++;
        if (batch_done !== 1'b1 || write_count !== 8'(want)) begin
            n_err++;
            $display("FAIL zero_count: got done=%b count=%0d want done=1 count=%0d", batch_done, write_count, want);
        end
        n_cmp++;
        if (obs_q.size() != want || obs_q[obs_q.size()-1] !== AW'(8)) begin
            n_err++;
            $display("FAIL zero_writes: got %0d writes want %0d ending in reg 8", obs_q.size(), want);
        end
        seq_done = 1'b0;
        step();
    endtask

    task automatic test_done_restart();
        push(AW'(15), 32'h115);
        n_cmp++;
        if (batch_done !== 1'b0 || write_count !== 8'd0) begin
            n_err++;
            $display("FAIL restart_clear: got done=%b count=%0d want done=0 count=0", batch_done, write_count);
        end
        step();
        n_cmp++;
        if (rf_we !== 1'b1 || write_count !== 8'd1) begin
            n_err++;
            $display("FAIL restart_write: got we=%b count=%0d want we=1 count=1", rf_we, write_count);
        end
        seq_done = 1'b1;
        for (int i = 0; i < 20 && batch_done !== 1'b1; i++) step();
        n_cmp++;
        if (batch_done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_done: got %b want 1", batch_done);
        end
        seq_done = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            int n = $urandom_range(1, 10);
            int sent = 0;
            int exp_w = 0;
            bit took;
            for (int c = 0; c < 400 && sent < n; c++) begin
                port_busy = ($urandom_range(0, 2) == 0);
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    in_valid  = 1'b1;
                    in_regnum = AW'($urandom_range(0, 31));
                    in_data   = $urandom;
                end
                took = in_valid && (in_ready === 1'b1);
                if (took && !(ZF && in_regnum == '0)) exp_w++;
                step();
                if (took) begin
                    sent++;
                    in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            seq_done = 1'b1;
            for (int i = 0; i < 200 && batch_done !== 1'b1; i++) begin
                port_busy = ($urandom_range(0, 2) == 0);
                step();
            end
            port_busy = 1'b0;
            n_cmp++;
            if (sent != n || batch_done !== 1'b1 || write_count !== 8'(exp_w)) begin
                n_err++;
                $display("FAIL random_batch: got sent=%0d done=%b count=%0d want sent=%0d done=1 count=%0d",
                         sent, batch_done, write_count, n, exp_w);
            end
            seq_done = 1'b0;
            step();
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_regnum = '0;
        in_data   = '0;
        seq_done  = 1'b0;
        port_busy = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_zero();
        test_done_restart();
        test_random();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
